// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program memory, PC and run/step/halt sequencing.
// Each instruction takes two cycles: FETCH reads mem[pc] into the instruction
// register, EXEC presents it to the control unit and retires it.
module instruction_fetch_unit #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 10,
  parameter int                 DEPTH     = 256,
  parameter logic [INSTR_W-1:0] NOP_WORD  = 10'b1111000000,
  parameter logic [INSTR_W-1:0] HALT_WORD = 10'b1111111111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic               stall,
  input  logic               load_pc,
  input  logic [ADDR_W-1:0]  pc_value,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               prog_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                single_q, single_d;
  logic                halt_pend_q, halt_pend_d;
  logic                prog_err_q, prog_err_d;
  logic                mem_we;
  logic [INSTR_W-1:0]  fetch_word;

  logic [INSTR_W-1:0]  mem [DEPTH];

  assign fetch_word = mem[pc_q];

  // Program memory: host writes only while idle or halted; never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Next-state, PC update, fetch capture and write-rejection logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    single_d    = single_q;
    halt_pend_d = halt_pend_q;
    prog_err_d  = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        mem_we = prog_we;
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        if (run) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end
      end

      S_FETCH: begin
        prog_err_d = prog_we;
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        if (fetch_word == HALT_WORD) begin
          state_d     = S_HALT;
          halt_pend_d = 1'b0;
        end else begin
          instr_d = fetch_word;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        prog_err_d = prog_we;
        if (stall) begin
          // A halt request seen while stalled is remembered, not acted on yet.
          if (halt_req) begin
            halt_pend_d = 1'b1;
          end
        end else begin
          pc_d        = load_pc ? pc_value : pc_q + 1'b1;
          halt_pend_d = 1'b0;
          if (halt_req || halt_pend_q || single_q) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= NOP_WORD;
      single_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      prog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      single_q    <= single_d;
      halt_pend_q <= halt_pend_d;
      prog_err_q  <= prog_err_d;
    end
  end

  // Outputs decode from state so reset forces them immediately.
  always_comb begin
    instr_valid = (state_q == S_EXEC);
    instruction = (state_q == S_EXEC) ? instr_q : NOP_WORD;
    halted      = (state_q == S_HALT);
    pc          = pc_q;
    prog_err    = prog_err_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed program scenarios followed by
// randomized runs, with an instruction-level reference model feeding a scoreboard.
module tb_instruction_fetch_unit;

  localparam logic [9:0] NOPW  = 10'b1111000000;
  localparam logic [9:0] HALTW = 10'b1111111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0, step = 1'b0, halt_req = 1'b0, stall = 1'b0, load_pc = 1'b0;
  logic [7:0] pc_value = '0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = '0;
  logic [9:0] prog_data = '0;
  logic [9:0] instruction;
  logic       instr_valid;
  logic [7:0] pc;
  logic       halted;
  logic       prog_err;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_W   (8),
    .INSTR_W  (10),
    .DEPTH    (256),
    .NOP_WORD (NOPW),
    .HALT_WORD(HALTW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .halt_req   (halt_req),
    .stall      (stall),
    .load_pc    (load_pc),
    .pc_value   (pc_value),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted),
    .prog_err   (prog_err)
  );

  typedef struct packed {
    logic [9:0] word;
    logic [7:0] pc;
  } exp_t;

  int         vectors = 0;
  int         miscompares = 0;
  exp_t       sb_q[$];
  logic [9:0] mem_m [256];
  logic [7:0] mpc = '0;
  bit         pend = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every live instruction must match the head of the expected queue;
  // the entry retires on the first stall-free EXEC cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(instr_valid), 32'd0);
        end else begin
          check("instr_word", 32'(instruction), 32'(sb_q[0].word));
          check("instr_pc", 32'(pc), 32'(sb_q[0].pc));
          if (!stall) void'(sb_q.pop_front());
        end
      end else begin
        check("nop_when_idle", 32'(instruction), 32'(NOPW));
      end
    end
  end

  task automatic clear_inputs();
    run = 0; step = 0; halt_req = 0; stall = 0; load_pc = 0; prog_we = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", 32'(instruction), 32'(NOPW));
    check("rst_pc", 32'(pc), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_prog_err", 32'(prog_err), 0);
    rst_n = 1;
    mpc = '0;
    pend = 0;
    sb_q.delete();
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [9:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
    mem_m[a] = d;
    check("prog_err_idle", 32'(prog_err), 0);
  endtask

  // Runs the program from the current PC until the model says it halts.
  // mode: 0=run, 1=step, 2=run+step together (continuous).
  task automatic run_prog(input int mode, input bit rnd, input int max_instr,
                          input int stall_at, input int jump_at, input int jump_to);
    bit single, done, halting, inject, lp, hr, we;
    int n, k, retired;
    logic [7:0] tgt, nxt;
    exp_t e;
    single = (mode == 1);
    done = 0;
    retired = 0;
    run  = (mode != 1);
    step = (mode != 0);
    while (!done) begin
      halting = (mem_m[mpc] === HALTW);
      if (!halting) begin
        e.word = mem_m[mpc];
        e.pc   = mpc;
        sb_q.push_back(e);
      end
      inject = rnd && !halting && ($urandom_range(5) == 0);
      n = 0;
      do begin
        tick();
        n++;
        run = 0; step = 0; load_pc = 0; stall = 0; prog_we = 0;
        halt_req = (n == 1) && inject;
      end while (!instr_valid && !halted && n < 8);
      halt_req = 0;
      if (inject) pend = 1;
      check("latency", 32'(n), 32'd2);
      if (halting) begin
        check("halted_on_halt_word", 32'(halted), 1);
        check("halt_word_pc", 32'(pc), 32'(mpc));
        pend = 0;
        done = 1;
      end else begin
        check("exec_valid", 32'(instr_valid), 1);
        k = (int'(mpc) == stall_at) ? 3 : (rnd ? int'($urandom_range(2)) : 0);
        for (int i = 0; i < k; i++) begin
          we  = (int'(mpc) == stall_at) || (rnd && ($urandom_range(1) == 1));
          nxt = mpc + 8'd1;
          stall = 1; prog_we = we; prog_addr = nxt; prog_data = ~mem_m[nxt];
          load_pc = rnd && ($urandom_range(1) == 1);
          pc_value = 8'($urandom);
          tick();
          check("prog_err_busy", 32'(prog_err), 32'(we));
          check("stall_holds_exec", 32'(instr_valid), 1);
        end
        stall = 0; prog_we = 0;
        retired++;
        lp  = (int'(mpc) == jump_at) || (rnd && ($urandom_range(3) == 0));
        tgt = (int'(mpc) == jump_at) ? 8'(jump_to) : 8'($urandom);
        hr  = (retired >= max_instr) || (rnd && ($urandom_range(9) == 0));
        load_pc = lp; pc_value = tgt; halt_req = hr;
        mpc = lp ? tgt : mpc + 8'd1;
        if (hr || pend || single) begin
          tick();
          load_pc = 0; halt_req = 0;
          check("halt_after_exec", 32'(halted), 1);
          check("halt_pc", 32'(pc), 32'(mpc));
          check("halt_valid", 32'(instr_valid), 0);
          pend = 0;
          done = 1;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] w;
    exp_t e;
    do_reset();

    for (int a = 0; a < 256; a++) begin
      w = 10'($urandom);
      if (w == HALTW) w = '0;
      write_mem(8'(a), w);
    end

    // Straight-line program ending in HALT_WORD.
    write_mem(8'd0, 10'b0000001010);
    write_mem(8'd1, 10'b0010011101);
    write_mem(8'd2, 10'b1000100001);
    write_mem(8'd3, HALTW);
    run_prog(0, 0, 1000, -1, -1, 0);

    // Reset in the middle of EXEC, then rerun from retained memory.
    do_reset();
    for (int a = 0; a < 3; a++) begin
      e.word = mem_m[a];
      e.pc   = 8'(a);
      sb_q.push_back(e);
    end
    run = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      run = 0;
    end
    check("exec_before_reset", 32'(instr_valid), 1);
    check("pc_before_reset", 32'(pc), 2);
    rst_n = 0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 0);
    check("async_rst_instr", 32'(instruction), 32'(NOPW));
    check("async_rst_pc", 32'(pc), 0);
    check("async_rst_halted", 32'(halted), 0);
    sb_q.delete();
    tick();
    rst_n = 1;
    mpc = '0;
    pend = 0;
    run_prog(0, 0, 1000, -1, -1, 0);

    // Jump from address 1 to 5.
    do_reset();
    write_mem(8'd1, 10'b1001000101);
    write_mem(8'd6, HALTW);
    run_prog(0, 0, 1000, -1, 1, 5);

    // Three stall cycles on address 0 with rejected writes to address 1.
    do_reset();
    write_mem(8'd1, HALTW);
    run_prog(0, 0, 1000, 0, -1, 0);

    // PC wrap 255 -> 0 via a jump to 255.
    do_reset();
    write_mem(8'd0, 10'b0001000001);
    write_mem(8'd255, 10'b0101010101);
    run_prog(0, 0, 4, -1, 0, 255);

    // Single steps from HALT; the second step reads back address 1.
    run_prog(1, 0, 1000, 0, -1, 0);
    run_prog(1, 0, 1000, -1, -1, 0);

    // Write and run together in HALT, run+step means continuous.
    write_mem(mpc + 8'd1, 10'b0011001100);
    prog_we = 1; prog_addr = mpc; prog_data = 10'b0110110110;
    mem_m[mpc] = 10'b0110110110;
    run_prog(2, 0, 2, -1, -1, 0);

    // Randomized programs, jumps, stalls and halt requests.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(7) == 0) do_reset();
      for (int j = 0; j < int'($urandom_range(3)); j++) begin
        w = ($urandom_range(7) == 0) ? HALTW : 10'($urandom);
        write_mem(8'($urandom), w);
      end
      run_prog(int'($urandom_range(2)), 1, 1 + int'($urandom_range(9)), -1, -1, 0);
    end

    tick();
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
